// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipeline control path: opcodes, select codes and the
// decoded control bundle carried from ID into EX.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int IMM_W   = 3;
    localparam int SRCA_W  = 2;
    localparam int RES_W   = 2;
    localparam int ALUOP_W = 2;
    localparam int FWD_W   = 2;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_W-1:0] IMM_U = 3'b100;

    localparam logic [SRCA_W-1:0] SRCA_RS1  = 2'b00;
    localparam logic [SRCA_W-1:0] SRCA_ZERO = 2'b01;
    localparam logic [SRCA_W-1:0] SRCA_PC   = 2'b10;

    localparam logic [RES_W-1:0] RES_ALU  = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM  = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4  = 2'b10;
    localparam logic [RES_W-1:0] RES_NONE = 2'b11;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_BR  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_FN  = 2'b10;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                reg_write;
        logic [IMM_W-1:0]    imm_src;
        logic [SRCA_W-1:0]   alu_src_a;
        logic                alu_src_b;
        logic                mem_write;
        logic [RES_W-1:0]    result_src;
        logic                branch;
        logic [ALUOP_W-1:0]  alu_op;
        logic                jump;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Bundle between the datapath and the control path; clk and rst stay outside.
interface ctrl_pipeline_if #(parameter int REG_AW = 5);
    import ctrl_pkg::*;

    logic                instr_valid_d;
    logic [6:0]          opcode_d;
    logic [REG_AW-1:0]   rd_d;
    logic [REG_AW-1:0]   rs1_d;
    logic [REG_AW-1:0]   rs2_d;
    logic [REG_AW-1:0]   rs1_e;
    logic [REG_AW-1:0]   rs2_e;
    logic                pc_src_e;

    logic [IMM_W-1:0]    imm_src_d;
    logic                illegal_d;
    logic                stall_f;
    logic                stall_d;
    logic                flush_d;
    logic [ALUOP_W-1:0]  alu_op_e;
    logic [SRCA_W-1:0]   alu_src_a_e;
    logic                alu_src_b_e;
    logic                branch_e;
    logic                jump_e;
    logic [FWD_W-1:0]    forward_a_e;
    logic [FWD_W-1:0]    forward_b_e;
    logic                mem_write_m;
    logic                reg_write_m;
    logic [RES_W-1:0]    result_src_m;
    logic [REG_AW-1:0]   rd_m;
    logic                reg_write_w;
    logic [RES_W-1:0]    result_src_w;
    logic [REG_AW-1:0]   rd_w;
    logic                illegal_sticky;

    modport master (
        output instr_valid_d, opcode_d, rd_d, rs1_d, rs2_d, rs1_e, rs2_e, pc_src_e,
        input  imm_src_d, illegal_d, stall_f, stall_d, flush_d,
               alu_op_e, alu_src_a_e, alu_src_b_e, branch_e, jump_e,
               forward_a_e, forward_b_e, mem_write_m, reg_write_m, result_src_m, rd_m,
               reg_write_w, result_src_w, rd_w, illegal_sticky
    );

    modport slave (
        input  instr_valid_d, opcode_d, rd_d, rs1_d, rs2_d, rs1_e, rs2_e, pc_src_e,
        output imm_src_d, illegal_d, stall_f, stall_d, flush_d,
               alu_op_e, alu_src_a_e, alu_src_b_e, branch_e, jump_e,
               forward_a_e, forward_b_e, mem_write_m, reg_write_m, result_src_m, rd_m,
               reg_write_w, result_src_w, rd_w, illegal_sticky
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational ID decoder: opcode to control bundle, source-use flags and the
// unknown-opcode flag. Invalid or unknown instructions decode as a bubble.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic       i_valid,
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_use_rs1,
    output logic       o_use_rs2,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_use_rs1 = 1'b0;
        o_use_rs2 = 1'b0;
        o_illegal = 1'b0;
        if (i_valid) begin
            case (i_opcode)
                OP_LOAD: begin
                    o_ctrl    = '{1'b1, IMM_I, SRCA_RS1, 1'b1, 1'b0, RES_MEM, 1'b0, ALU_ADD, 1'b0};
                    o_use_rs1 = 1'b1;
                end
                OP_STORE: begin
                    o_ctrl    = '{1'b0, IMM_S, SRCA_RS1, 1'b1, 1'b1, RES_NONE, 1'b0, ALU_ADD, 1'b0};
                    o_use_rs1 = 1'b1;
                    o_use_rs2 = 1'b1;
                end
                OP_R: begin
                    o_ctrl    = '{1'b1, IMM_I, SRCA_RS1, 1'b0, 1'b0, RES_ALU, 1'b0, ALU_FN, 1'b0};
                    o_use_rs1 = 1'b1;
                    o_use_rs2 = 1'b1;
                end
                OP_I: begin
                    o_ctrl    = '{1'b1, IMM_I, SRCA_RS1, 1'b1, 1'b0, RES_ALU, 1'b0, ALU_FN, 1'b0};
                    o_use_rs1 = 1'b1;
                end
                OP_BRANCH: begin
                    o_ctrl    = '{1'b0, IMM_B, SRCA_RS1, 1'b0, 1'b0, RES_NONE, 1'b1, ALU_BR, 1'b0};
                    o_use_rs1 = 1'b1;
                    o_use_rs2 = 1'b1;
                end
                OP_JAL:   o_ctrl = '{1'b1, IMM_J, SRCA_PC, 1'b1, 1'b0, RES_PC4, 1'b0, ALU_ADD, 1'b1};
                OP_LUI:   o_ctrl = '{1'b1, IMM_U, SRCA_ZERO, 1'b1, 1'b0, RES_ALU, 1'b0, ALU_ADD, 1'b0};
                OP_AUIPC: o_ctrl = '{1'b1, IMM_U, SRCA_PC, 1'b1, 1'b0, RES_ALU, 1'b0, ALU_ADD, 1'b0};
                OP_JALR: begin
                    o_ctrl    = '{1'b1, IMM_I, SRCA_RS1, 1'b1, 1'b0, RES_PC4, 1'b0, ALU_ADD, 1'b1};
                    o_use_rs1 = 1'b1;
                end
                default:  o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control path for the 5-stage pipeline: decode, ID/EX, EX/MEM, MEM/WB control
// registers, RAW/load-use stall detection, EX forwarding select and flush.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter bit FWD_EN       = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input logic            clk,
    input logic            rst,
    ctrl_pipeline_if.slave bus
);

    ctrl_t              w_ctrl_d;
    logic               w_use_rs1;
    logic               w_use_rs2;
    logic               w_illegal_raw;
    logic               w_rs1_live;
    logic               w_rs2_live;
    logic               w_hit_e;
    logic               w_hit_m;
    logic               w_hazard;
    logic               w_stall;
    logic               w_illegal;
    logic               w_load_e;
    logic [FWD_W-1:0]   w_fwd_a;
    logic [FWD_W-1:0]   w_fwd_b;

    logic               r_reg_write_e;
    logic               r_mem_write_e;
    logic [RES_W-1:0]   r_result_src_e;
    logic [ALUOP_W-1:0] r_alu_op_e;
    logic [SRCA_W-1:0]  r_alu_src_a_e;
    logic               r_alu_src_b_e;
    logic               r_branch_e;
    logic               r_jump_e;
    logic [REG_AW-1:0]  r_rd_e;
    logic               r_reg_write_m;
    logic               r_mem_write_m;
    logic [RES_W-1:0]   r_result_src_m;
    logic [REG_AW-1:0]  r_rd_m;
    logic               r_reg_write_w;
    logic [RES_W-1:0]   r_result_src_w;
    logic [REG_AW-1:0]  r_rd_w;
    logic               r_illegal_sticky;

    ctrl_decode u_decode (
        .i_valid   (bus.instr_valid_d),
        .i_opcode  (bus.opcode_d),
        .o_ctrl    (w_ctrl_d),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2),
        .o_illegal (w_illegal_raw)
    );

    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              rw_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              rw_w,
        input logic [REG_AW-1:0] rd_w
    );
        if (rs == '0) return FWD_RF;
        if (rw_m && rd_m == rs) return FWD_MEM;
        if (rw_w && rd_w == rs) return FWD_WB;
        return FWD_RF;
    endfunction

    // x0 sources are excluded up front, so an equality hit implies a nonzero rd.
    always_comb begin
        w_rs1_live = w_use_rs1 && (bus.rs1_d != '0);
        w_rs2_live = w_use_rs2 && (bus.rs2_d != '0);
        w_hit_e    = (w_rs1_live && bus.rs1_d == r_rd_e) || (w_rs2_live && bus.rs2_d == r_rd_e);
        w_hit_m    = (w_rs1_live && bus.rs1_d == r_rd_m) || (w_rs2_live && bus.rs2_d == r_rd_m);
        if (FWD_EN) begin
            w_hazard = (r_result_src_e == RES_MEM) && w_hit_e;
            w_fwd_a  = fwd_sel(bus.rs1_e, r_reg_write_m, r_rd_m, r_reg_write_w, r_rd_w);
            w_fwd_b  = fwd_sel(bus.rs2_e, r_reg_write_m, r_rd_m, r_reg_write_w, r_rd_w);
        end else begin
            w_hazard = (r_reg_write_e && w_hit_e) || (r_reg_write_m && w_hit_m);
            w_fwd_a  = FWD_RF;
            w_fwd_b  = FWD_RF;
        end
        w_stall   = w_hazard && !bus.pc_src_e;
        w_illegal = ILLEGAL_TRAP && w_illegal_raw && !bus.pc_src_e;
        w_load_e  = bus.instr_valid_d && !w_illegal_raw && !w_stall && !bus.pc_src_e;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write_e    <= 1'b0;
            r_mem_write_e    <= 1'b0;
            r_result_src_e   <= '0;
            r_alu_op_e       <= '0;
            r_alu_src_a_e    <= '0;
            r_alu_src_b_e    <= 1'b0;
            r_branch_e       <= 1'b0;
            r_jump_e         <= 1'b0;
            r_rd_e           <= '0;
            r_reg_write_m    <= 1'b0;
            r_mem_write_m    <= 1'b0;
            r_result_src_m   <= '0;
            r_rd_m           <= '0;
            r_reg_write_w    <= 1'b0;
            r_result_src_w   <= '0;
            r_rd_w           <= '0;
            r_illegal_sticky <= 1'b0;
        end else begin
            if (w_load_e) begin
                r_reg_write_e  <= w_ctrl_d.reg_write;
                r_mem_write_e  <= w_ctrl_d.mem_write;
                r_result_src_e <= w_ctrl_d.result_src;
                r_alu_op_e     <= w_ctrl_d.alu_op;
                r_alu_src_a_e  <= w_ctrl_d.alu_src_a;
                r_alu_src_b_e  <= w_ctrl_d.alu_src_b;
                r_branch_e     <= w_ctrl_d.branch;
                r_jump_e       <= w_ctrl_d.jump;
                r_rd_e         <= bus.rd_d;
            end else begin
                r_reg_write_e  <= 1'b0;
                r_mem_write_e  <= 1'b0;
                r_result_src_e <= '0;
                r_alu_op_e     <= '0;
                r_alu_src_a_e  <= '0;
                r_alu_src_b_e  <= 1'b0;
                r_branch_e     <= 1'b0;
                r_jump_e       <= 1'b0;
                r_rd_e         <= '0;
            end
            r_reg_write_m  <= r_reg_write_e;
            r_mem_write_m  <= r_mem_write_e;
            r_result_src_m <= r_result_src_e;
            r_rd_m         <= r_rd_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
            r_rd_w         <= r_rd_m;
            if (w_illegal) r_illegal_sticky <= 1'b1;
        end
    end

    assign bus.imm_src_d      = w_ctrl_d.imm_src;
    assign bus.illegal_d      = w_illegal;
    assign bus.stall_f        = w_stall;
    assign bus.stall_d        = w_stall;
    assign bus.flush_d        = bus.pc_src_e;
    assign bus.alu_op_e       = r_alu_op_e;
    assign bus.alu_src_a_e    = r_alu_src_a_e;
    assign bus.alu_src_b_e    = r_alu_src_b_e;
    assign bus.branch_e       = r_branch_e;
    assign bus.jump_e         = r_jump_e;
    assign bus.forward_a_e    = w_fwd_a;
    assign bus.forward_b_e    = w_fwd_b;
    assign bus.mem_write_m    = r_mem_write_m;
    assign bus.reg_write_m    = r_reg_write_m;
    assign bus.result_src_m   = r_result_src_m;
    assign bus.rd_m           = r_rd_m;
    assign bus.reg_write_w    = r_reg_write_w;
    assign bus.result_src_w   = r_result_src_w;
    assign bus.rd_w           = r_rd_w;
    assign bus.illegal_sticky = r_illegal_sticky;

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Parametrised next-generation control path for the 5-stage RISC-V pipeline. It decodes the ID-stage opcode into the control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also performs load-use/RAW stall detection, EX-stage forwarding selection and taken-branch/jump flushing. It sits beside the datapath; the datapath keeps its own data pipeline registers and uses this block's stall/flush outputs.

Parameters:
REG_AW, 5, register-address width for rd/rs1/rs2.
FWD_EN, 1, 1: forwarding plus load-use stall; 0: no forwarding, stall on any RAW hazard against EX or MEM.
ILLEGAL_TRAP, 1, 1: an unknown opcode raises illegal_d and sets illegal_sticky; 0: an unknown opcode becomes a silent bubble.

Ports:
clk  in  1  pipeline clock.
rst  in  1  asynchronous, active-high reset.
instr_valid_d  in  1  ID holds a real instruction.
opcode_d  in  7  ID opcode.
rd_d, rs1_d, rs2_d  in  REG_AW each  ID register fields.
rs1_e, rs2_e  in  REG_AW each  EX source fields, from the datapath ID/EX register.
pc_src_e  in  1  taken branch or jump resolved in EX.
imm_src_d  out  3  ID immediate select; combinational.
illegal_d  out  1  ID opcode is illegal; combinational; 0 when ILLEGAL_TRAP=0.
stall_f, stall_d  out  1 each  hold PC and the IF/ID register.
flush_d  out  1  clear the IF/ID register.
alu_op_e, alu_src_a_e  out  2 each  EX controls.
alu_src_b_e, branch_e, jump_e  out  1 each  EX controls.
forward_a_e, forward_b_e  out  2 each  00 regfile, 01 WB result, 10 MEM ALU result.
mem_write_m, reg_write_m  out  1 each  MEM controls.
result_src_m  out  2  MEM control.
rd_m  out  REG_AW  MEM destination register.
reg_write_w  out  1  WB control.
result_src_w  out  2  WB control.
rd_w  out  REG_AW  WB destination register.
illegal_sticky  out  1  set by any illegal instruction; cleared only by rst.

Behaviour:
- Reset is asynchronous and active-high. All stage registers clear to a bubble: every output listed above resets to 0, and illegal_sticky resets to 0.
- Decode fields, in order: regWrite, immSrc, aluSrcA, aluSrcB, memWrite, resultSrc, branch, aluOp, jump.
  - LOAD 0000011: 1, 000, 00, 1, 0, 01, 0, 00, 0.
  - STORE 0100011: 0, 001, 00, 1, 1, 11, 0, 00, 0.
  - R 0110011: 1, 000, 00, 0, 0, 00, 0, 10, 0.
  - I 0010011: 1, 000, 00, 1, 0, 00, 0, 10, 0.
  - BRANCH 1100011: 0, 010, 00, 0, 0, 11, 1, 01, 0.
  - JAL 1101111: 1, 011, 10, 1, 0, 10, 0, 00, 1.
  - LUI 0110111: 1, 100, 01, 1, 0, 00, 0, 00, 0.
  - AUIPC 0010111: 1, 100, 10, 1, 0, 00, 0, 00, 0.
  - JALR 1100111: 1, 000, 00, 1, 0, 10, 0, 00, 1.
  - Any other opcode, or instr_valid_d=0: all fields 0 (bubble).
- Source-use flags:
  - use_rs1 = 0 for LUI, AUIPC and JAL; 1 for every other valid instruction.
  - use_rs2 = 1 only for R, STORE and BRANCH.
  - Register 0 never matches in any hazard or forwarding compare.
- Pipeline advance: one stage per cycle. MEM<=EX and WB<=MEM advance unconditionally; there is no back-end stall.
- FWD_EN=1:
  - forward_x_e = 10 if reg_write_m and rd_m==rsx_e (nonzero).
  - Otherwise 01 if reg_write_w and rd_w==rsx_e (nonzero).
  - Otherwise 00. MEM has priority over WB.
  - Load-use: result_src_e==01 and rd_e matches a used rs of ID. Then stall_f=stall_d=1 and EX loads a bubble next edge.
- FWD_EN=0:
  - forward outputs are tied to 00.
  - Stall when a used ID rs matches a nonzero rd in EX or MEM with regWrite set.
  - WB is not checked; the register file writes before it reads.
- Flush: pc_src_e=1 gives flush_d=1 and EX loads a bubble next edge. Flush beats stall: stall_f and stall_d are forced to 0 in that cycle.
- Stall bubble: ID controls are not captured, and EX receives all-zero controls.
- A stall persists while the hazard holds. A load-use stall lasts exactly 1 cycle because the load then moves to MEM.
- Illegal (ILLEGAL_TRAP=1): instr_valid_d with an unknown opcode and no stall or flush in that cycle.
  - illegal_sticky is set on the next edge; illegal_d is high combinationally.
  - The instruction enters EX as a bubble.
- A mid-operation rst clears all stages immediately, so no partial writes propagate after release.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams;
  - imm_src, result_src and alu_src_a encodings;
  - forward-select encodings;
  - the control-bundle field widths.
- Sub-module ctrl_decode: the combinational opcode-to-bundle decoder, including use_rs1, use_rs2 and the illegal flag.
- ctrl_pipeline instantiates ctrl_decode and contains the stage registers, hazard logic and forwarding logic.

Test Plan:
- Reset, then R-type add x3,x1,x2 (0110011): three cycles later reg_write_w=1, rd_w=3, result_src_w=00; all outputs are 0 during rst.
- lw x5 in EX, then add x6,x5,x7 in ID (FWD_EN=1): stall_f=stall_d=1 for 1 cycle, EX bubble; next cycle forward_a_e=01.
- add x4 in MEM, add x4 in WB, EX reads x4: forward_a_e=10 (MEM priority).
- Branch in EX with pc_src_e=1 while a load-use hazard condition is forced: flush_d=1, stall_f=0, EX next cycle is a bubble.
- FWD_EN=0: addi x8 in EX, then sw x8 in ID: stall for 2 cycles, forward outputs stay 00.
- Opcode 1111111 with valid=1 (ILLEGAL_TRAP=1): illegal_d=1, illegal_sticky=1 from the next cycle until rst; EX is a bubble; a LUI to x0 never triggers a stall.
